// File: rtl/fifo_buffer_if.sv
// rtl/fifo_buffer_if.sv - write/read bus between the pixel writer, the delay-line reader and the FIFO
interface fifo_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;

   modport master (
      output wr_en, rd_en, wr_data,
      input  rd_data, full, empty, count
   );

   modport slave (
      input  wr_en, rd_en, wr_data,
      output rd_data, full, empty, count
   );
endinterface

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - single-clock FIFO with registered read data, used as a pixel delay line
module fifo_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   fifo_buffer_if.slave    bus
);

   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   logic full;
   logic empty;
   logic rd_accept;
   logic wr_accept;

   // Status decodes straight from count; a write into a full FIFO is allowed when a read frees a slot in the same cycle
   always_comb begin
      full      = (count_q == FULL_COUNT);
      empty     = (count_q == '0);
      rd_accept = bus.rd_en && !empty;
      wr_accept = bus.wr_en && (!full || rd_accept);
   end

   // Next pointers, occupancy and read register; the read samples the old head even if the same slot is written now
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (rd_accept) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         rd_data_d = mem[rd_ptr_q];
      end

      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage array; never cleared, only accepted writes outside reset land in it
   always_ff @(posedge clk) begin
      if (rst && wr_accept) begin
         mem[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.full    = full;
   assign bus.empty   = empty;
   assign bus.count   = count_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - self-checking bench for fifo_buffer against a queue-based model
module tb_fifo_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int NSTREAM = 20000;
   localparam int LAG     = 252;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   fifo_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

   fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   byte unsigned mq[$];
   logic [DW-1:0] m_rd = '0;
   byte unsigned s[NSTREAM];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of bytes plus the last value handed to the reader
   always @(posedge clk) begin
      if (!rst) begin
         mq.delete();
         m_rd = '0;
      end else begin
         bit ra;
         bit wa;
         ra = bus.rd_en && (mq.size() > 0);
         wa = bus.wr_en && ((mq.size() < DEPTH) || ra);
         if (ra) m_rd = mq.pop_front();
         if (wa) mq.push_back(bus.wr_data);
      end
   end

   // Every cycle, compare all outputs against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("model_rd_data", 32'(bus.rd_data), 32'(m_rd));
         chk("model_count",   32'(bus.count),   32'(mq.size()));
         chk("model_empty",   32'(bus.empty),   32'(mq.size() == 0));
         chk("model_full",    32'(bus.full),    32'(mq.size() == DEPTH));
      end
   end

   task automatic step(input logic rst_n, input logic w, input logic r, input logic [DW-1:0] d);
      rst         = rst_n;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.wr_data = d;
      @(negedge clk);
   endtask

   initial begin
      int pw;
      int pr;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_data = '0;
      rst         = 1'b0;
      @(negedge clk);

      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      checking = 1'b1;
      chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
      chk("reset_empty",   32'(bus.empty),   32'h1);
      chk("reset_full",    32'(bus.full),    32'h0);
      chk("reset_count",   32'(bus.count),   32'h0);

      step(1'b1, 1'b1, 1'b0, 8'h11);
      step(1'b1, 1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b1, 1'b0, 8'h33);
      chk("basic_count3", 32'(bus.count), 32'd3);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("basic_rd0", 32'(bus.rd_data), 32'h11);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("basic_rd1", 32'(bus.rd_data), 32'h22);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("basic_rd2",   32'(bus.rd_data), 32'h33);
      chk("basic_count", 32'(bus.count),   32'd0);
      chk("basic_empty", 32'(bus.empty),   32'h1);

      for (int k = 0; k < NSTREAM; k++) begin
         s[k] = 8'($urandom);
         step(1'b1, 1'b1, (k >= LAG), s[k]);
         if (k >= LAG) begin
            chk("stream_delay", 32'(bus.rd_data), 32'(s[k - LAG]));
            chk("stream_count", 32'(bus.count),   32'd252);
         end
      end

      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("stream_reset_count", 32'(bus.count), 32'd0);

      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'(i));
      end
      chk("full_flag",  32'(bus.full),  32'h1);
      chk("full_count", 32'(bus.count), 32'd256);
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      chk("full_drop_count", 32'(bus.count), 32'd256);
      chk("full_drop_flag",  32'(bus.full),  32'h1);
      step(1'b1, 1'b1, 1'b1, 8'hBB);
      chk("full_rw_rd",    32'(bus.rd_data), 32'h00);
      chk("full_rw_count", 32'(bus.count),   32'd256);
      for (int i = 1; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 1'b1, 8'h00);
         chk("full_drain", 32'(bus.rd_data), 32'(i));
      end
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("full_drain_last", 32'(bus.rd_data), 32'hBB);
      chk("full_drain_empty", 32'(bus.empty), 32'h1);

      step(1'b1, 1'b1, 1'b0, 8'h5C);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("empty_pre_rd", 32'(bus.rd_data), 32'h5C);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("empty_hold_rd",    32'(bus.rd_data), 32'h5C);
      chk("empty_hold_count", 32'(bus.count),   32'd0);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      chk("empty_rw_count", 32'(bus.count),   32'd1);
      chk("empty_rw_rd",    32'(bus.rd_data), 32'h5C);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("empty_rw_next", 32'(bus.rd_data), 32'h77);

      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'($urandom));
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("midrst_count", 32'(bus.count),   32'd0);
      chk("midrst_rd",    32'(bus.rd_data), 32'h0);
      chk("midrst_empty", 32'(bus.empty),   32'h1);
      step(1'b1, 1'b1, 1'b0, 8'h3C);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("midrst_after", 32'(bus.rd_data), 32'h3C);

      for (int c = 0; c < 6000; c++) begin
         pw = ((c / 700) % 2 == 0) ? 85 : 20;
         pr = ((c / 700) % 2 == 0) ? 25 : 80;
         step(($urandom_range(499) != 0),
              ($urandom_range(99) < pw),
              ($urandom_range(99) < pr),
              8'($urandom));
      end

      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
